// File: rtl/ariane_pkg.sv
// ariane_pkg: shared frontend types and helpers.
//   branchpredict      - resolution/update record driven by the EX branch unit
//   branchpredict_sbe  - prediction hint attached to a fetched instruction
//   btb_entry_t        - one branch target buffer entry
//   sat_inc / sat_dec  - saturating counter helpers (shared with future BHT)
package ariane_pkg;

    localparam int BTB_ENTRIES             = 64;
    localparam int BITS_SATURATION_COUNTER = 2;
    localparam int BTB_TAG_BITS            = 8;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_lower_16;
        logic        is_mispredict;
        logic        is_taken;
        logic        clear;
    } branchpredict;

    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        is_lower_16;
    } branchpredict_sbe;

    typedef struct packed {
        logic                               valid;
        logic [BTB_TAG_BITS-1:0]            tag;
        logic [63:0]                        target;
        logic                               is_lower_16;
        logic [BITS_SATURATION_COUNTER-1:0] cnt;
    } btb_entry_t;

    // Increment, holding at all-ones.
    function automatic logic [BITS_SATURATION_COUNTER-1:0] sat_inc(
        input logic [BITS_SATURATION_COUNTER-1:0] c
    );
        if (c == {BITS_SATURATION_COUNTER{1'b1}}) begin
            sat_inc = c;
        end else begin
            sat_inc = c + {{(BITS_SATURATION_COUNTER-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decrement, holding at zero.
    function automatic logic [BITS_SATURATION_COUNTER-1:0] sat_dec(
        input logic [BITS_SATURATION_COUNTER-1:0] c
    );
        if (c == {BITS_SATURATION_COUNTER{1'b0}}) begin
            sat_dec = c;
        end else begin
            sat_dec = c - {{(BITS_SATURATION_COUNTER-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer.
//   clk_i            - clock
//   rst_i            - synchronous active-high reset (clears all state)
//   flush_i          - invalidate every entry (valid and counter cleared)
//   vpc_i            - fetch PC, looked up combinationally
//   branch_predict_i - update from the EX branch unit
//   branch_predict_o - prediction for vpc_i (all zero on a miss)
// Entry widths come from btb_entry_t, so TAG_BITS and BITS_SATURATION_COUNTER
// must stay equal to the package widths.
module btb
    import ariane_pkg::*;
#(
    parameter int NR_ENTRIES              = BTB_ENTRIES,
    parameter int BITS_SATURATION_COUNTER = ariane_pkg::BITS_SATURATION_COUNTER,
    parameter int TAG_BITS                = BTB_TAG_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [63:0]      vpc_i,
    input  branchpredict     branch_predict_i,
    output branchpredict_sbe branch_predict_o
);

    localparam int IDX = $clog2(NR_ENTRIES);

    btb_entry_t r_btb [NR_ENTRIES];

    logic [IDX-1:0]      w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    btb_entry_t          w_lk_entry;
    logic                w_lk_hit;

    logic [IDX-1:0]      w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;
    btb_entry_t          w_up_entry;
    logic                w_up_hit;

    // Bits of the inputs that carry no meaning for the BTB.
    logic w_unused_bits;
    assign w_unused_bits = ^{vpc_i[63:IDX+TAG_BITS+2], vpc_i[0],
                             branch_predict_i.pc[63:IDX+TAG_BITS+2],
                             branch_predict_i.pc[1:0],
                             branch_predict_i.is_mispredict};

    assign w_lk_idx   = vpc_i[IDX+1:2];
    assign w_lk_tag   = vpc_i[IDX+TAG_BITS+1:IDX+2];
    assign w_lk_entry = r_btb[w_lk_idx];

    assign w_up_idx   = branch_predict_i.pc[IDX+1:2];
    assign w_up_tag   = branch_predict_i.pc[IDX+TAG_BITS+1:IDX+2];
    assign w_up_entry = r_btb[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    // A compressed branch in the lower half-word is behind a fetch that
    // already starts at the upper half, so it must not predict.
    assign w_lk_hit = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag) &&
                      !(vpc_i[1] && w_lk_entry.is_lower_16);

    // Combinational lookup; outputs stay zero unless the entry hits.
    always_comb begin
        branch_predict_o = '0;
        if (w_lk_hit) begin
            branch_predict_o.valid           = 1'b1;
            branch_predict_o.predict_taken   = w_lk_entry.cnt[BITS_SATURATION_COUNTER-1];
            branch_predict_o.predict_address = w_lk_entry.target;
            branch_predict_o.is_lower_16     = w_lk_entry.is_lower_16;
        end else begin
            branch_predict_o = '0;
        end
    end

    // Entry storage: reset > flush > update; one write per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].cnt   <= '0;
            end
        end else if (branch_predict_i.valid) begin
            if (branch_predict_i.clear) begin
                r_btb[w_up_idx].valid <= 1'b0;
                r_btb[w_up_idx].cnt   <= '0;
            end else if (w_up_hit) begin
                if (branch_predict_i.is_taken) begin
                    r_btb[w_up_idx].cnt         <= sat_inc(w_up_entry.cnt);
                    r_btb[w_up_idx].target      <= branch_predict_i.target_address;
                    r_btb[w_up_idx].is_lower_16 <= branch_predict_i.is_lower_16;
                end else begin
                    r_btb[w_up_idx].cnt <= sat_dec(w_up_entry.cnt);
                end
            end else if (branch_predict_i.is_taken) begin
                // Allocate or replace as weakly taken; not-taken misses never allocate.
                r_btb[w_up_idx].valid       <= 1'b1;
                r_btb[w_up_idx].tag         <= w_up_tag;
                r_btb[w_up_idx].target      <= branch_predict_i.target_address;
                r_btb[w_up_idx].is_lower_16 <= branch_predict_i.is_lower_16;
                r_btb[w_up_idx].cnt         <= {1'b1, {(BITS_SATURATION_COUNTER-1){1'b0}}};
            end else begin
                r_btb[w_up_idx] <= w_up_entry;
            end
        end else begin
            r_btb[w_up_idx] <= w_up_entry;
        end
    end

endmodule

// File: tb/tb_btb.sv
// tb_btb: directed self-checking bench for btb.
module tb_btb;
    import ariane_pkg::*;

    logic             clk;
    logic             rst_i;
    logic             flush_i;
    logic [63:0]      vpc_i;
    branchpredict     bp_i;
    branchpredict_sbe bp_o;

    int n_cmp = 0;
    int n_err = 0;

    btb dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .vpc_i            (vpc_i),
        .branch_predict_i (bp_i),
        .branch_predict_o (bp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Look up pc (no clock edge) and settle.
    task automatic look(input logic [63:0] pc);
        vpc_i = pc;
        #1;
    endtask

    // Present an update for one edge, then remove it.
    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt,
                       input logic taken, input logic low16, input logic clr);
        bp_i = '0;
        bp_i.valid          = 1'b1;
        bp_i.pc             = pc;
        bp_i.target_address = tgt;
        bp_i.is_taken       = taken;
        bp_i.is_lower_16    = low16;
        bp_i.clear          = clr;
        bp_i.is_mispredict  = 1'b1;
        @(posedge clk);
        #1;
        bp_i = '0;
    endtask

    // Look up A and check valid / taken.
    task automatic expect_vt(input string name, input logic [63:0] pc,
                             input logic v, input logic t);
        look(pc);
        check({name, ".valid"}, {63'd0, bp_o.valid}, {63'd0, v});
        check({name, ".taken"}, {63'd0, bp_o.predict_taken}, {63'd0, t});
    endtask

    localparam logic [63:0] PC_A  = 64'h0000_0000_8000_0010;
    localparam logic [63:0] PC_A2 = 64'h0000_0000_8000_0012;
    localparam logic [63:0] PC_AL = 64'h0000_0000_8000_0110;
    localparam logic [63:0] PC_B  = 64'h0000_0000_8000_0020;
    localparam logic [63:0] PC_C  = 64'h0000_0000_8000_0040;

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        vpc_i   = 64'd0;
        bp_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        look(PC_A);
        check("rst.valid", {63'd0, bp_o.valid}, 64'd0);
        check("rst.taken", {63'd0, bp_o.predict_taken}, 64'd0);
        check("rst.addr", bp_o.predict_address, 64'd0);
        check("rst.low16", {63'd0, bp_o.is_lower_16}, 64'd0);

        // Allocation: same-cycle lookup sees old contents
        vpc_i = PC_A;
        bp_i = '0;
        bp_i.valid = 1'b1; bp_i.pc = PC_A; bp_i.target_address = 64'h8000_0100;
        bp_i.is_taken = 1'b1;
        #1;
        check("alloc.same_cycle", {63'd0, bp_o.valid}, 64'd0);
        @(posedge clk);
        #1;
        bp_i = '0;
        #1;
        check("alloc.valid", {63'd0, bp_o.valid}, 64'd1);
        check("alloc.taken", {63'd0, bp_o.predict_taken}, 64'd1);
        check("alloc.addr", bp_o.predict_address, 64'h8000_0100);
        // Upper-half fetch of a 32-bit branch still hits
        expect_vt("upper32", PC_A2, 1'b1, 1'b1);

        // Counter: 2 -> 1 -> 0 -> 0 (floor)
        upd(PC_A, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
        expect_vt("nt1", PC_A, 1'b1, 1'b0);
        upd(PC_A, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
        expect_vt("nt2", PC_A, 1'b1, 1'b0);
        upd(PC_A, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
        expect_vt("nt3", PC_A, 1'b1, 1'b0);
        // 0 -> 1 -> 2 -> 3 -> 3 (ceiling)
        upd(PC_A, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
        expect_vt("t1", PC_A, 1'b1, 1'b0);
        upd(PC_A, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
        expect_vt("t2", PC_A, 1'b1, 1'b1);
        upd(PC_A, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
        upd(PC_A, 64'h8000_0180, 1'b1, 1'b0, 1'b0);
        expect_vt("t4", PC_A, 1'b1, 1'b1);
        check("t4.addr_rewrite", bp_o.predict_address, 64'h8000_0180);
        // 3 -> 2 still taken, 2 -> 1 not taken
        upd(PC_A, 64'h8000_0180, 1'b0, 1'b0, 1'b0);
        expect_vt("sat_nt1", PC_A, 1'b1, 1'b1);
        upd(PC_A, 64'h8000_0180, 1'b0, 1'b0, 1'b0);
        expect_vt("sat_nt2", PC_A, 1'b1, 1'b0);

        // Alias at index 4 with a different tag
        expect_vt("alias.miss", PC_AL, 1'b0, 1'b0);
        upd(PC_AL, 64'h8000_0200, 1'b1, 1'b0, 1'b0);
        expect_vt("alias.new", PC_AL, 1'b1, 1'b1);
        check("alias.addr", bp_o.predict_address, 64'h8000_0200);
        expect_vt("alias.old", PC_A, 1'b0, 1'b0);
        check("alias.old_addr", bp_o.predict_address, 64'd0);

        // Not-taken miss never allocates
        upd(PC_B, 64'h8000_0500, 1'b0, 1'b0, 1'b0);
        expect_vt("nt_noalloc", PC_B, 1'b0, 1'b0);

        // Compressed entry
        upd(PC_A, 64'h8000_0300, 1'b1, 1'b1, 1'b0);
        expect_vt("c16.lo", PC_A, 1'b1, 1'b1);
        check("c16.low16", {63'd0, bp_o.is_lower_16}, 64'd1);
        check("c16.addr", bp_o.predict_address, 64'h8000_0300);
        expect_vt("c16.hi", PC_A2, 1'b0, 1'b0);
        check("c16.hi_addr", bp_o.predict_address, 64'd0);

        // Clear invalidates
        upd(PC_A, 64'h0, 1'b0, 1'b0, 1'b1);
        expect_vt("clear", PC_A, 1'b0, 1'b0);

        // Flush beats a simultaneous allocation
        upd(PC_A, 64'h8000_0600, 1'b1, 1'b0, 1'b0);
        expect_vt("pre_flush", PC_A, 1'b1, 1'b1);
        flush_i = 1'b1;
        upd(PC_C, 64'h8000_0700, 1'b1, 1'b0, 1'b0);
        flush_i = 1'b0;
        expect_vt("flush.C", PC_C, 1'b0, 1'b0);
        expect_vt("flush.A", PC_A, 1'b0, 1'b0);

        // Reset mid-stream drops the concurrent update and clears state
        upd(PC_A, 64'h8000_0800, 1'b1, 1'b0, 1'b0);
        expect_vt("pre_rst", PC_A, 1'b1, 1'b1);
        rst_i = 1'b1;
        upd(PC_C, 64'h8000_0900, 1'b1, 1'b0, 1'b0);
        rst_i = 1'b0;
        expect_vt("rst2.A", PC_A, 1'b0, 1'b0);
        expect_vt("rst2.C", PC_C, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
